memctrl: RTL and testbench

- Synchronous single-port byte-wide memory controller with an embedded 64 KiB storage array.
- Accepts SRAM-style chip-select, write-enable and output-enable strobes from a host.
- Performs one read or one write per clock cycle.
- Drives registered read data onto ODATA, gated by the output-enable strobe.
- Sits between a simple host/bus master and on-chip storage; used as the memory endpoint in SoC bring-up.

---
 rtl/memctrl.sv | 93 +++++++++
 tb/tb_memctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/memctrl.sv
// memctrl: single-port byte-wide SRAM-style memory controller.
// One read or one write per rising edge, with a registered read path
// and ODATA gated combinationally by the output enable.
// Reset asserts asynchronously; its release passes through a two-stage chain
// before any command is accepted.
module memctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RSTN,   // active-high asynchronous reset
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              CE,
    input  logic              CSB,
    input  logic              WEB,
    input  logic              OEB,
    input  logic [DATA_W-1:0] IDATA,
    output logic [DATA_W-1:0] ODATA
);

    // Last command type, kept for debug visibility.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        rel_q;
    logic              cmd_v;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset release chain: clears instantly on reset, fills with ones afterwards.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            rel_q <= '0;
        end else begin
            rel_q <= {rel_q[0], 1'b1};
        end
    end

    // Command decode; write wins over read when WEB and OEB are both low.
    always_comb begin
        cmd_v   = CE && !CSB && rel_q[1];
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        state_d = state_q;
        if (!cmd_v) begin
            state_d = ST_IDLE;
        end else if (!WEB) begin
            wr_en   = 1'b1;
            state_d = ST_WRITE;
        end else if (!OEB) begin
            rd_en   = 1'b1;
            state_d = ST_READ;
        end
    end

    // Debug state register.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage array; never reset so it maps onto a plain single-port RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[ADDR] <= IDATA;
        end
    end

    // Registered read data, held until the next read.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem_q[ADDR];
        end
    end

    // Output gating follows OEB without waiting for a clock edge.
    always_comb begin
        ODATA = OEB ? '0 : rd_q;
    end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: randomized and directed checks of memctrl against a
// behavioural memory model held in plain arrays.
module tb_memctrl;

    logic       CLK;
    logic       RSTN;
    logic [15:0] ADDR;
    logic       CE;
    logic       CSB;
    logic       WEB;
    logic       OEB;
    logic [7:0] IDATA;
    logic [7:0] ODATA;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic [7:0] m_mem [65536];
    bit         m_val [65536];
    logic [7:0] m_rd    = 8'h00;
    bit         m_known = 1'b1;
    int         rel_cnt = 0;

    memctrl #(
        .ADDR_W(16),
        .DATA_W(8)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .ADDR (ADDR),
        .CE   (CE),
        .CSB  (CSB),
        .WEB  (WEB),
        .OEB  (OEB),
        .IDATA(IDATA),
        .ODATA(ODATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: ODATA=%02h expected=%02h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a command is honoured once three edges have passed since
    // reset release; the bench never issues commands on edges two and three.
    always @(posedge CLK) begin
        if (RSTN) begin
            m_rd    = 8'h00;
            m_known = 1'b1;
            rel_cnt = 0;
        end else begin
            if (rel_cnt >= 3 && CE && !CSB) begin
                if (!WEB) begin
                    m_mem[ADDR] = IDATA;
                    m_val[ADDR] = 1'b1;
                end else if (!OEB) begin
                    m_rd    = m_mem[ADDR];
                    m_known = m_val[ADDR];
                end
            end
            if (rel_cnt < 3) rel_cnt++;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (OEB || RSTN) begin
            e = 8'h00;
            check("model", ODATA, e);
        end else if (m_known) begin
            e = m_rd;
            check("model", ODATA, e);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_set();
        CE  = 1'b0;
        CSB = 1'b1;
        WEB = 1'b1;
    endtask

    task automatic idle(input int n);
        idle_set();
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; OEB = 1'b1;
        ADDR = a; IDATA = d;
        cyc();
        idle_set();
    endtask

    task automatic rd(input logic [15:0] a);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
        ADDR = a;
        cyc();
        idle_set();
    endtask

    initial begin
        logic [7:0] seq_b [10];
        RSTN = 1'b0; CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b0;
        ADDR = '0; IDATA = '0;

        // Reset with OEB low.
        #1 RSTN = 1'b1;
        #1 check("rst_assert", ODATA, 8'h00);
        repeat (3) @(posedge CLK);
        #2 RSTN = 1'b0;
        check("rst_release", ODATA, 8'h00);
        idle(4);
        check("rst_no_read", ODATA, 8'h00);

        // Write then read after idle; read data holds after deselect.
        wr(16'h0000, 8'hA5);
        OEB = 1'b1;
        idle(10);
        rd(16'h0000);
        check("rd_a5", ODATA, 8'hA5);
        idle(3);
        check("hold_a5", ODATA, 8'hA5);

        // Deselected writes must not land.
        wr(16'h0010, 8'hC3);
        CE = 1'b1; CSB = 1'b1; WEB = 1'b0; OEB = 1'b1; ADDR = 16'h0010; IDATA = 8'h3C;
        cyc();
        idle_set();
        rd(16'h0010);
        check("csb_desel", ODATA, 8'hC3);
        CE = 1'b0; CSB = 1'b0; WEB = 1'b0; OEB = 1'b1; ADDR = 16'h0010; IDATA = 8'h3C;
        cyc();
        idle_set();
        rd(16'h0010);
        check("ce_desel", ODATA, 8'hC3);

        // Output enable gates ODATA combinationally.
        rd(16'h0000);
        OEB = 1'b1;
        #1 check("oeb_high", ODATA, 8'h00);
        OEB = 1'b0;
        #1 check("oeb_low", ODATA, 8'hA5);

        // Write/read sequence over addresses 0..9.
        for (int n = 0; n < 10; n++) begin
            seq_b[n] = 8'($urandom);
            wr(16'(n), seq_b[n]);
            rd(16'(n));
            check("seq", ODATA, seq_b[n]);
        end

        // Write priority: WEB and OEB both low performs only the write.
        wr(16'h0000, 8'hA5);
        rd(16'h0000);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; OEB = 1'b0; ADDR = 16'h0020; IDATA = 8'h5A;
        cyc();
        idle_set();
        check("wr_prio_hold", ODATA, 8'hA5);
        rd(16'h0020);
        check("wr_prio_data", ODATA, 8'h5A);

        // Randomized traffic over a small window of addresses.
        for (int i = 0; i < 400; i++) begin
            CE    = ($urandom_range(0, 3) != 0);
            CSB   = ($urandom_range(0, 3) == 0);
            WEB   = 1'($urandom);
            OEB   = 1'($urandom);
            ADDR  = 16'h0040 + 16'($urandom_range(0, 15));
            IDATA = 8'($urandom);
            cyc();
        end
        idle_set();

        // Asynchronous reset in the middle of a held read.
        rd(16'h0000);
        check("pre_rst", ODATA, 8'hA5);
        #1 RSTN = 1'b1;
        #1 check("midrst_clear", ODATA, 8'h00);
        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; ADDR = 16'h0000; IDATA = 8'h66;
        repeat (2) cyc();
        RSTN = 1'b0;
        cyc();
        idle_set();
        check("post_rst_zero", ODATA, 8'h00);
        idle(3);
        rd(16'h0000);
        check("post_rst_mem", ODATA, 8'hA5);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
